// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich spike event encoder: voltage width,
// default payload width, rate saturation value and detector state encoding.
package izh_pkg;

  localparam int         V_W      = 8;
  localparam int         TS_W_DEF = 16;
  localparam logic [7:0] RATE_SAT = 8'd255;

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_FIRED = 1'b1
  } det_state_e;

endpackage

// File: rtl/izh_event_fifo.sv
// Synchronous DEPTH x W event FIFO with registered storage, valid/ready pop side
// and full/empty flags. A push into a full FIFO is accepted only if a pop happens too.
module izh_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         pop, do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop     = !empty && pop_ready;
    do_push = push && (!full || pop);
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  assign head_data = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      // NOTE: storage is reset because the head register is a visible output that must read 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/izh_spike_event_encoder.sv
// Spike detector with hysteresis, timestamped event FIFO and windowed rate count.
// Define IZH_SPIKE_ISI_EN to report inter-spike intervals instead of timestamps.
module izh_spike_event_encoder
  import izh_pkg::*;
#(
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_LOG2   = 10,
  parameter int HYST       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [V_W-1:0]  v_in,
  input  logic [V_W-1:0]  thresh,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [TS_W-1:0] evt_data,
  output logic            ovf,
  input  logic            ovf_clr,
  output logic [7:0]      rate_cnt,
  output logic            rate_vld
);

  det_state_e           state_q, state_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [WIN_LOG2-1:0]  win_q, win_d;
  logic [7:0]           acc_q, acc_d, rate_q, rate_d;
  logic                 rate_vld_q, rate_vld_d;
  logic                 push_q, push_d;
  logic [TS_W-1:0]      pay_q, pay_d;
  logic                 ovf_q, ovf_d;
  logic                 spike, wrap, fifo_full, fifo_empty, fifo_drop;
  logic signed [8:0]    rearm9;
  logic signed [7:0]    rearm;
  logic [8:0]           acc_sum;
  logic [7:0]           acc_sat;
  logic [TS_W-1:0]      stamp;

`ifdef IZH_SPIKE_ISI_EN
  logic [TS_W-1:0] isi_q, isi_d;

  // Cycles since the last detected spike; all-ones means "unknown or too long ago".
  always_comb begin
    isi_d = isi_q;
    if (spike)                    isi_d = TS_W'(1);
    else if (ena && isi_q != '1)  isi_d = isi_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) isi_q <= '1;
    else        isi_q <= isi_d;
  end

  assign stamp = isi_q;
`else
  assign stamp = ts_q;
`endif

  always_comb begin
    rearm9 = $signed({thresh[7], thresh}) - $signed(9'(HYST));
    rearm  = (rearm9 < -9'sd128) ? -8'sd128 : $signed(rearm9[7:0]);
    spike  = ena && (state_q == ST_ARMED) && ($signed(v_in) > $signed(thresh));

    state_d = state_q;
    if (ena) begin
      case (state_q)
        ST_ARMED: if ($signed(v_in) > $signed(thresh)) state_d = ST_FIRED;
        ST_FIRED: if ($signed(v_in) < rearm)           state_d = ST_ARMED;
      endcase
    end

    ts_d  = ena ? ts_q + 1'b1 : ts_q;
    win_d = ena ? win_q + 1'b1 : win_q;
    wrap  = ena && (win_q == '1);

    acc_sum    = {1'b0, acc_q} + {8'd0, spike};
    acc_sat    = acc_sum[8] ? RATE_SAT : acc_sum[7:0];
    acc_d      = acc_sat;
    rate_d     = rate_q;
    rate_vld_d = 1'b0;
    if (wrap) begin
      rate_d     = acc_sat;
      rate_vld_d = 1'b1;
      acc_d      = '0;
    end

    // Detected events are staged one cycle before entering the FIFO.
    push_d = spike;
    pay_d  = spike ? stamp : pay_q;
    ovf_d  = fifo_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  assign fifo_drop = push_q && fifo_full && !(evt_valid && evt_ready);

  izh_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (pay_q),
    .pop_ready (evt_ready),
    .head_data (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARMED;
      ts_q       <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      rate_q     <= '0;
      rate_vld_q <= 1'b0;
      push_q     <= 1'b0;
      pay_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      rate_q     <= rate_d;
      rate_vld_q <= rate_vld_d;
      push_q     <= push_d;
      pay_q      <= pay_d;
      ovf_q      <= ovf_d;
    end
  end

  assign evt_valid = !fifo_empty;
  assign ovf       = ovf_q;
  assign rate_cnt  = rate_q;
  assign rate_vld  = rate_vld_q;

endmodule

// File: tb/tb_izh_spike_event_encoder.sv
// Self-checking bench for izh_spike_event_encoder: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_izh_spike_event_encoder;

  localparam int DEPTH = 4;
  localparam int WLOG  = 4;
  localparam int HYST  = 8;

  logic        clk, rst_n, ena, evt_ready, ovf_clr;
  logic [7:0]  v_in, thresh;
  logic        evt_valid, ovf, rate_vld;
  logic [15:0] evt_data;
  logic [7:0]  rate_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  izh_spike_event_encoder #(
    .TS_W       (16),
    .FIFO_DEPTH (DEPTH),
    .WIN_LOG2   (WLOG),
    .HYST       (HYST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .v_in      (v_in),
    .thresh    (thresh),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .rate_cnt  (rate_cnt),
    .rate_vld  (rate_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state, expressed in spec terms.
  bit          m_armed;
  longint      m_en_cnt;
  longint      m_last;
  bit          m_have_last;
  int          m_acc, m_rate;
  bit          m_rate_vld, m_ovf, m_pend;
  logic [15:0] m_pend_pay;
  logic [15:0] mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 1; m_en_cnt = 0; m_last = 0; m_have_last = 0;
    m_acc = 0; m_rate = 0; m_rate_vld = 0; m_ovf = 0; m_pend = 0; m_pend_pay = '0;
    mq.delete();
  endtask

  task automatic model_step(input bit e, input logic signed [7:0] v, input logic signed [7:0] th,
                            input bit rdy, input bit clr);
    int     rearm;
    bit     pop, drop, spk;
    longint diff;
    pop  = (mq.size() > 0) && rdy;
    drop = 0;
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() >= DEPTH) drop = 1;
      else mq.push_back(m_pend_pay);
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    rearm = int'(th) - HYST;
    if (rearm < -128) rearm = -128;
    spk    = e && m_armed && (int'(v) > int'(th));
    m_pend = spk;
    if (spk) begin
`ifdef IZH_SPIKE_ISI_EN
      diff        = m_en_cnt - m_last;
      m_pend_pay  = (!m_have_last || diff >= 65535) ? 16'hFFFF : 16'(diff);
      m_have_last = 1;
      m_last      = m_en_cnt;
`else
      diff        = m_en_cnt;
      m_pend_pay  = 16'(diff);
`endif
    end
    m_rate_vld = 0;
    if (e) begin
      if (m_armed && int'(v) > int'(th)) m_armed = 0;
      else if (!m_armed && int'(v) < rearm) m_armed = 1;
      if (m_en_cnt % (1 << WLOG) == (1 << WLOG) - 1) begin
        m_rate     = (m_acc + int'(spk) > 255) ? 255 : m_acc + int'(spk);
        m_rate_vld = 1;
        m_acc      = 0;
      end else begin
        m_acc = (m_acc + int'(spk) > 255) ? 255 : m_acc + int'(spk);
      end
      m_en_cnt++;
    end
  endtask

  task automatic cyc(input bit e, input logic signed [7:0] v, input logic signed [7:0] th,
                     input bit rdy, input bit clr);
    ena = e; v_in = v; thresh = th; evt_ready = rdy; ovf_clr = clr;
    model_step(e, v, th, rdy, clr);
    @(posedge clk); #1;
    check("evt_valid", {31'd0, evt_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) check("evt_data", {16'd0, evt_data}, {16'd0, mq[0]});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check("rate_cnt", {24'd0, rate_cnt}, m_rate);
    check("rate_vld", {31'd0, rate_vld}, {31'd0, m_rate_vld});
  endtask

  task automatic do_reset();
    ena = 0; evt_ready = 0; ovf_clr = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst evt_valid", {31'd0, evt_valid}, 0);
    check("rst evt_data", {16'd0, evt_data}, 0);
    check("rst ovf", {31'd0, ovf}, 0);
    check("rst rate_cnt", {24'd0, rate_cnt}, 0);
    check("rst rate_vld", {31'd0, rate_vld}, 0);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct packed {
    logic              e;
    logic signed [7:0] v;
    logic              exp_valid;
    logic [15:0]       exp_data;
  } vec_t;

`ifdef IZH_SPIKE_ISI_EN
  localparam logic [15:0] T1_D0 = 16'hFFFF, T1_D1 = 16'd4;
  localparam logic [15:0] T6_D0 = 16'hFFFF, T6_D1 = 16'd7, T6_D2 = 16'd10, T6_RST = 16'hFFFF;
`else
  localparam logic [15:0] T1_D0 = 16'd1, T1_D1 = 16'd5;
  localparam logic [15:0] T6_D0 = 16'd10, T6_D1 = 16'd17, T6_D2 = 16'd27, T6_RST = 16'd3;
`endif

  vec_t        tbl[8];
  logic [15:0] got[$];
  int          pops, events, pulses;
  int          pulse_tick[$];
  int          tick;

  initial begin
    rst_n = 1'b0; ena = 0; v_in = '0; thresh = '0; evt_ready = 0; ovf_clr = 0;
    model_reset();

    // Test 1: hysteresis threshold, table-driven.
    tbl[0] = '{1'b1,  8'sd0,  1'b0, 16'd0};
    tbl[1] = '{1'b1,  8'sd35, 1'b0, 16'd0};
    tbl[2] = '{1'b1,  8'sd40, 1'b1, T1_D0};
    tbl[3] = '{1'b1,  8'sd25, 1'b0, 16'd0};
    tbl[4] = '{1'b1,  8'sd21, 1'b0, 16'd0};
    tbl[5] = '{1'b1,  8'sd35, 1'b0, 16'd0};
    tbl[6] = '{1'b1,  8'sd0,  1'b1, T1_D1};
    tbl[7] = '{1'b1,  8'sd0,  1'b0, 16'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].e, tbl[i].v, 8'sd30, 1'b1, 1'b0);
      check("t1 valid", {31'd0, evt_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check("t1 data", {16'd0, evt_data}, {16'd0, tbl[i].exp_data});
    end

    // Test 2: overflow with consumer stalled, then drain and clear.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 8'sd100, 8'sd30, 0, 0);
      cyc(1, -8'sd100, 8'sd30, 0, 0);
    end
    cyc(0, 8'sd0, 8'sd30, 0, 0);
    check("t2 ovf", {31'd0, ovf}, 1);
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (evt_valid) pops++;
      cyc(0, 8'sd0, 8'sd30, 1, 0);
    end
    check("t2 pops", pops, 4);
    check("t2 empty", {31'd0, evt_valid}, 0);
    cyc(0, 8'sd0, 8'sd30, 0, 1);
    check("t2 ovf_clr", {31'd0, ovf}, 0);

    // Test 3: push into a full FIFO while popping is not a drop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'sd100, 8'sd30, 0, 0);
      cyc(1, -8'sd100, 8'sd30, 0, 0);
    end
    cyc(1, 8'sd100, 8'sd30, 0, 0);
    cyc(1, -8'sd100, 8'sd30, 1, 0);
    cyc(0, 8'sd0, 8'sd30, 0, 0);
    check("t3 ovf", {31'd0, ovf}, 0);
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (evt_valid) pops++;
      cyc(0, 8'sd0, 8'sd30, 1, 0);
    end
    check("t3 count", pops, 4);

    // Test 4: rate window, with ena held low for 5 cycles mid-window.
    do_reset();
    tick = 0;
    pulse_tick.delete();
    for (int i = 0; i < 48; i++) begin
      if (i == 40) begin
        for (int k = 0; k < 5; k++) begin
          cyc(0, 8'sd0, 8'sd30, 1, 0);
          tick++;
          if (rate_vld) pulse_tick.push_back(tick);
        end
      end
      cyc(1, (i % 4 == 0) ? 8'sd100 : -8'sd100, 8'sd30, 1, 0);
      tick++;
      if (rate_vld) begin
        pulse_tick.push_back(tick);
        check("t4 rate_cnt", {24'd0, rate_cnt}, 4);
      end
    end
    check("t4 pulses", pulse_tick.size(), 3);
    if (pulse_tick.size() == 3) begin
      check("t4 pulse0", pulse_tick[0], 16);
      check("t4 pulse1", pulse_tick[1], 32);
      check("t4 pulse2", pulse_tick[2], 53);
    end

    // Test 5: re-arm level saturating at -128.
    do_reset();
    events = 0;
    cyc(1, -8'sd100, -8'sd121, 1, 0);
    for (int i = 0; i < 4; i++) begin
      if (evt_valid) events++;
      cyc(1, -8'sd128, -8'sd121, 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      if (evt_valid) events++;
      cyc(1, -8'sd100, -8'sd121, 1, 0);
    end
    if (evt_valid) events++;
    check("t5 sat no rearm", events, 1);
    cyc(1, -8'sd128, -8'sd119, 1, 0);
    cyc(1, -8'sd100, -8'sd119, 1, 0);
    cyc(1, -8'sd100, -8'sd119, 1, 0);
    check("t5 rearm -127", {31'd0, evt_valid}, 1);

    // Test 6: payload sequence, then reset mid-run.
    do_reset();
    got.delete();
    for (int t = 0; t < 31; t++) begin
      cyc(1, (t == 10 || t == 17 || t == 27) ? 8'sd100 : -8'sd100, 8'sd30, 1, 0);
      if (evt_valid) got.push_back(evt_data);
    end
    check("t6 n_events", got.size(), 3);
    if (got.size() == 3) begin
      check("t6 evt0", {16'd0, got[0]}, {16'd0, T6_D0});
      check("t6 evt1", {16'd0, got[1]}, {16'd0, T6_D1});
      check("t6 evt2", {16'd0, got[2]}, {16'd0, T6_D2});
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'sd100, 8'sd30, 0, 0);
      cyc(1, -8'sd100, 8'sd30, 0, 0);
    end
    cyc(1, -8'sd100, 8'sd30, 0, 0);
    check("t6 ovf before rst", {31'd0, ovf}, 1);
    do_reset();
    got.delete();
    for (int t = 0; t < 6; t++) begin
      cyc(1, (t == 3) ? 8'sd100 : -8'sd100, 8'sd30, 1, 0);
      if (evt_valid) got.push_back(evt_data);
    end
    check("t6 post-rst events", got.size(), 1);
    if (got.size() == 1) check("t6 post-rst data", {16'd0, got[0]}, {16'd0, T6_RST});

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic signed [7:0] th;
      th = (i % 500 < 250) ? 8'sd20 : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 9) < 8), 8'($urandom_range(0, 255)), th,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
